// File: rtl/rm32_fht_decoder.sv
// Soft-decision RM(32,6) decoder: sequential 32-point FHT followed by an argmax search.
// Define RM32_DECODER_METRIC_EN to drive the winning magnitude on out_metric; otherwise it is tied to 0.
module rm32_fht_decoder #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH + 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_symbol,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [5:0]            out_bits,
  output logic [ACC_WIDTH-1:0]  out_metric,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FHT,
    S_SEARCH,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [ACC_WIDTH-1:0] sym_buf [32];

  logic [4:0]           cnt_q;
  logic [2:0]           stage_q;
  logic [3:0]           pair_q;
  logic [4:0]           best_idx_q;
  logic                 best_neg_q;
  logic [ACC_WIDTH-1:0] best_mag_q;

  logic [4:0]                  idx_a, idx_b;
  logic signed [ACC_WIDTH-1:0] op_a, op_b, cur;
  logic [ACC_WIDTH-1:0]        cur_mag;
  logic                        cur_neg;
  logic                        load_fire, fht_last, search_last;

  // Butterfly address: insert a 0 at bit position 'stage' into the pair index,
  // which walks pairs in ascending 'a' within each stage.
  always_comb begin
    idx_a = '0;
    case (stage_q)
      3'd0:    idx_a = {pair_q, 1'b0};
      3'd1:    idx_a = {pair_q[3:1], 1'b0, pair_q[0]};
      3'd2:    idx_a = {pair_q[3:2], 1'b0, pair_q[1:0]};
      3'd3:    idx_a = {pair_q[3], 1'b0, pair_q[2:0]};
      3'd4:    idx_a = {1'b0, pair_q};
      default: idx_a = '0;
    endcase
    idx_b = idx_a | (5'd1 << stage_q);
  end

  assign op_a = sym_buf[idx_a];
  assign op_b = sym_buf[idx_b];

  // Two's complement negate of the most negative value yields its exact unsigned magnitude.
  assign cur     = sym_buf[cnt_q];
  assign cur_neg = cur[ACC_WIDTH-1];
  assign cur_mag = cur_neg ? ACC_WIDTH'(-cur) : ACC_WIDTH'(cur);

  assign load_fire   = (state_q == S_LOAD) && in_valid;
  assign fht_last    = (stage_q == 3'd4) && (pair_q == 4'd15);
  assign search_last = (cnt_q == 5'd31);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (cnt_q == 5'd31)) state_d = S_FHT;
      end
      S_FHT: begin
        if (fht_last) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (search_last) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // cnt wraps to 0 after the 32nd load and after the 32nd search step,
  // so it is already cleared when each of those phases begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      stage_q    <= '0;
      pair_q     <= '0;
      best_idx_q <= '0;
      best_neg_q <= 1'b0;
      best_mag_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD: begin
          if (in_valid) cnt_q <= cnt_q + 1'b1;
        end
        S_FHT: begin
          pair_q <= pair_q + 1'b1;
          if (pair_q == 4'd15) stage_q <= stage_q + 1'b1;
          if (fht_last) begin
            stage_q    <= '0;
            best_idx_q <= '0;
            best_neg_q <= 1'b0;
            best_mag_q <= '0;
          end
        end
        S_SEARCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cur_mag > best_mag_q) begin
            best_mag_q <= cur_mag;
            best_idx_q <= cnt_q;
            best_neg_q <= cur_neg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        sym_buf[cnt_q] <= ACC_WIDTH'(signed'(in_symbol));
      end else if (state_q == S_FHT) begin
        sym_buf[idx_a] <= op_a + op_b;
        sym_buf[idx_b] <= op_a - op_b;
      end
    end
  end

  assign out_bits = {best_neg_q, best_idx_q};

`ifdef RM32_DECODER_METRIC_EN
  assign out_metric = best_mag_q;
`else
  assign out_metric = '0;
`endif

endmodule
